// File: rtl/trail_stack.sv
// trail_stack: LIFO assignment trail for the DPLL engine.
// It records decided and implied assignments, tracks the decision level, and
// on bt_start pops one entry per cycle until the most recent decision is removed.
//
// state | meaning
// IDLE  | accepting push / pop / bt_start
// BT    | autonomous backtrack, one pop per cycle, inputs ignored
module trail_stack #(
    parameter int VAR_BITS = 8,
    parameter int DEPTH    = 256,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic [VAR_BITS-1:0] push_var,
    input  logic                push_val,
    input  logic                push_dec,
    input  logic                pop,
    input  logic                bt_start,
    output logic                out_valid,
    output logic [VAR_BITS-1:0] out_var,
    output logic                out_val,
    output logic                out_dec,
    output logic                busy,
    output logic                bt_done,
    output logic                bt_unsat,
    output logic [CNT_W-1:0]    count,
    output logic [CNT_W-1:0]    level,
    output logic                empty,
    output logic                full,
    output logic                overflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = VAR_BITS + 2;

    typedef enum logic {IDLE, BT} state_t;

    state_t             state, state_n;
    logic [ENT_W-1:0]   mem [DEPTH];
    logic [ENT_W-1:0]   top;
    logic [IDX_W-1:0]   top_idx;
    logic               top_dec;
    logic [CNT_W-1:0]   count_n, level_n;
    logic               emit, wr_en, done_n, unsat_n, overflow_n;
    logic [IDX_W-1:0]   wr_idx;

    // Entry layout {var, val, dec}; the top entry sits at index count-1.
    assign top_idx = IDX_W'(count - CNT_W'(1));
    assign top     = mem[top_idx];
    assign top_dec = top[0];

    // Next-state, counter and pop/push decisions; bt_start dominates in IDLE.
    always_comb begin
        state_n    = state;
        count_n    = count;
        level_n    = level;
        emit       = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = IDX_W'(count);
        done_n     = 1'b0;
        unsat_n    = 1'b0;
        overflow_n = overflow;
        case (state)
            IDLE: begin
                if (bt_start) begin
                    if (empty) begin
                        unsat_n = 1'b1;
                    end else begin
                        emit    = 1'b1;
                        count_n = count - CNT_W'(1);
                        if (top_dec) begin
                            level_n = level - CNT_W'(1);
                            done_n  = 1'b1;
                        end else if (count == CNT_W'(1)) begin
                            unsat_n = 1'b1;
                        end else begin
                            state_n = BT;
                        end
                    end
                end else if (push && pop && !empty) begin
                    // Replace the top in place: count stays, level follows the dec bits.
                    emit    = 1'b1;
                    wr_en   = 1'b1;
                    wr_idx  = top_idx;
                    level_n = level + CNT_W'(push_dec) - CNT_W'(top_dec);
                end else if (pop && !empty) begin
                    emit    = 1'b1;
                    count_n = count - CNT_W'(1);
                    level_n = level - CNT_W'(top_dec);
                end else if (push) begin
                    if (full) begin
                        overflow_n = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        count_n = count + CNT_W'(1);
                        level_n = level + CNT_W'(push_dec);
                    end
                end
            end
            BT: begin
                emit    = 1'b1;
                count_n = count - CNT_W'(1);
                if (top_dec) begin
                    level_n = level - CNT_W'(1);
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (count == CNT_W'(1)) begin
                    unsat_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Trail storage, deliberately not reset; count bounds what is meaningful.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= {push_var, push_val, push_dec};
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            level     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_var   <= '0;
            out_val   <= 1'b0;
            out_dec   <= 1'b0;
            bt_done   <= 1'b0;
            bt_unsat  <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            level     <= level_n;
            empty     <= (count_n == '0);
            full      <= (count_n == CNT_W'(DEPTH));
            overflow  <= overflow_n;
            busy      <= (state_n == BT);
            out_valid <= emit;
            bt_done   <= done_n;
            bt_unsat  <= unsat_n;
            if (emit) begin
                {out_var, out_val, out_dec} <= top;
            end
        end
    end

endmodule

// File: tb/tb_trail_stack.sv
// tb_trail_stack: directed test-plan scenarios followed by random traffic,
// each cycle compared against a queue-based model of the trail.
module tb_trail_stack;

    localparam int VB    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [VB-1:0] v;
        logic          val;
        logic          dec;
    } ent_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0, push_val = 1'b0, push_dec = 1'b0, pop = 1'b0, bt_start = 1'b0;
    logic [VB-1:0] push_var = '0;
    logic          out_valid, out_val, out_dec, busy, bt_done, bt_unsat, empty, full, overflow;
    logic [VB-1:0] out_var;
    logic [CW-1:0] count, level;

    int checks = 0;
    int errors = 0;

    ent_t q[$];
    bit   m_bt  = 0;
    bit   m_ovf = 0;

    trail_stack #(.VAR_BITS(VB), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .push(push), .push_var(push_var), .push_val(push_val), .push_dec(push_dec),
        .pop(pop), .bt_start(bt_start),
        .out_valid(out_valid), .out_var(out_var), .out_val(out_val), .out_dec(out_dec),
        .busy(busy), .bt_done(bt_done), .bt_unsat(bt_unsat),
        .count(count), .level(level), .empty(empty), .full(full), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_level();
        int n = 0;
        foreach (q[i]) n += int'(q[i].dec);
        return n;
    endfunction

    task automatic check_status();
        check("count", 32'(count), 32'(q.size()));
        check("level", 32'(level), 32'(model_level()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("busy", 32'(busy), 32'(m_bt));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        push = 0; pop = 0; bt_start = 0;
        @(posedge clock); #1;
        q.delete(); m_bt = 0; m_ovf = 0;
        check_status();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_var", 32'(out_var), 0);
        check("rst_out_val", 32'(out_val), 0);
        check("rst_out_dec", 32'(out_dec), 0);
        check("rst_bt_done", 32'(bt_done), 0);
        check("rst_bt_unsat", 32'(bt_unsat), 0);
        reset = 1'b0;
    endtask

    // One clock: drive inputs, advance, apply the trail rules to the model, compare.
    task automatic step(input logic p, input logic o, input logic b,
                        input logic [VB-1:0] v, input logic vl, input logic d);
        ent_t popped;
        bit   e_valid = 0, e_done = 0, e_unsat = 0;
        push = p; pop = o; bt_start = b; push_var = v; push_val = vl; push_dec = d;
        @(posedge clock); #1;
        popped = '0;
        if (m_bt || b) begin
            if (q.size() == 0) begin
                e_unsat = 1;
            end else begin
                popped  = q.pop_back();
                e_valid = 1;
                if (popped.dec) begin
                    e_done = 1; m_bt = 0;
                end else if (q.size() == 0) begin
                    e_unsat = 1; m_bt = 0;
                end else begin
                    m_bt = 1;
                end
            end
        end else if (o && q.size() > 0) begin
            popped  = q.pop_back();
            e_valid = 1;
            if (p) q.push_back('{v: v, val: vl, dec: d});
        end else if (p) begin
            if (q.size() == DEPTH) m_ovf = 1;
            else q.push_back('{v: v, val: vl, dec: d});
        end
        check_status();
        check("out_valid", 32'(out_valid), 32'(e_valid));
        check("bt_done", 32'(bt_done), 32'(e_done));
        check("bt_unsat", 32'(bt_unsat), 32'(e_unsat));
        if (e_valid) begin
            check("out_var", 32'(out_var), 32'(popped.v));
            check("out_val", 32'(out_val), 32'(popped.val));
            check("out_dec", 32'(out_dec), 32'(popped.dec));
        end
    endtask

    task automatic idle_step();
        step(0, 0, 0, 8'd0, 0, 0);
    endtask

    initial begin
        // Basic push/pop.
        do_reset();
        step(1, 0, 0, 8'd5, 1, 1);
        step(1, 0, 0, 8'd9, 0, 0);
        step(1, 0, 0, 8'd3, 1, 0);
        check("plan_count3", 32'(count), 3);
        check("plan_level1", 32'(level), 1);
        step(0, 1, 0, 8'd0, 0, 0);
        check("plan_pop_var", 32'(out_var), 3);

        // Backtrack to the decision on var 4; junk inputs while busy are ignored.
        do_reset();
        step(1, 0, 0, 8'd1, 1, 1);
        step(1, 0, 0, 8'd2, 0, 0);
        step(1, 0, 0, 8'd4, 1, 1);
        step(1, 0, 0, 8'd6, 0, 0);
        step(1, 0, 0, 8'd7, 1, 0);
        step(0, 0, 1, 8'd0, 0, 0);
        check("bt_first_var", 32'(out_var), 7);
        step(1, 1, 1, 8'd33, 1, 1);
        step(1, 0, 1, 8'd34, 0, 1);
        check("bt_last_var", 32'(out_var), 4);
        check("bt_done_seen", 32'(bt_done), 1);
        idle_step();
        check("bt_after_count", 32'(count), 2);
        check("bt_after_level", 32'(level), 1);

        // Exhausted trail, then backtrack on empty.
        do_reset();
        step(1, 0, 0, 8'd2, 0, 0);
        step(1, 0, 0, 8'd3, 0, 0);
        step(0, 0, 1, 8'd0, 0, 0);
        step(0, 1, 0, 8'd0, 0, 0);
        check("unsat_var", 32'(out_var), 2);
        step(0, 0, 1, 8'd0, 0, 0);
        check("unsat_empty", 32'(bt_unsat), 1);
        idle_step();

        // Overflow: DEPTH+1 pushes, then a pop keeps overflow set.
        do_reset();
        for (int i = 0; i <= DEPTH; i++) step(1, 0, 0, VB'(i + 10), 1, 0);
        check("ovf_count", 32'(count), DEPTH);
        step(0, 1, 0, 8'd0, 0, 0);
        check("ovf_sticky", 32'(overflow), 1);

        // Replace-top then pop.
        do_reset();
        step(1, 0, 0, 8'd1, 1, 1);
        step(1, 0, 0, 8'd6, 1, 0);
        step(1, 1, 0, 8'd8, 0, 1);
        check("rep_var", 32'(out_var), 6);
        step(0, 1, 0, 8'd0, 0, 0);
        check("rep_pop_var", 32'(out_var), 8);
        step(1, 1, 0, 8'd11, 1, 0);
        step(1, 1, 0, 8'd12, 0, 0);
        step(1, 1, 0, 8'd13, 1, 1);

        // Reset during a backtrack.
        do_reset();
        step(1, 0, 0, 8'd1, 1, 1);
        step(1, 0, 0, 8'd2, 0, 0);
        step(1, 0, 0, 8'd3, 0, 0);
        step(1, 0, 0, 8'd4, 0, 0);
        step(0, 0, 1, 8'd0, 0, 0);
        do_reset();
        idle_step();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 35),
                     1'($urandom_range(0, 99) < 7), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            end
        end
        for (int n = 0; n < DEPTH + 2; n++) idle_step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
